// File: rtl/regfile_rd_arbiter.sv
// Round-robin arbiter sharing the regfile read port; each winner gets a 1-4 beat read burst.
// Optional macro RF_ARB_PRIO0_EN gives requester 0 fixed highest priority at every arbitration.
module regfile_rd_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*AW-1:0]  addr,
  input  logic [N_REQ*2-1:0]   len,
  output logic [N_REQ-1:0]     gnt,
  output logic [AW-1:0]        rf_sel,
  input  logic [DW-1:0]        rf_rdata,
  output logic [DW-1:0]        rd_data,
  output logic [N_REQ-1:0]     rd_valid,
  output logic                 rd_last,
  output logic                 busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr, rr_nxt;
  logic [IW-1:0]     win, win_nxt;
  logic [IW-1:0]     pick;
  logic [AW-1:0]     cur_addr, addr_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [N_REQ-1:0]  gnt_nxt, vld_nxt;
  logic              last_nxt;
  logic [DW-1:0]     data_nxt;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[rr_idx(rr_ptr, k)]) pick = rr_idx(rr_ptr, k);
    end
`ifdef RF_ARB_PRIO0_EN
    if (req[0]) pick = '0;
`else
`endif
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    win_nxt   = win;
    addr_nxt  = cur_addr;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    vld_nxt   = '0;
    last_nxt  = 1'b0;
    data_nxt  = rd_data;
    case (state)
      IDLE: begin
        if (|req) begin
          win_nxt   = pick;
          gnt_nxt   = onehot(pick);
          addr_nxt  = addr[pick*AW +: AW];
          cnt_nxt   = len[pick*2 +: 2];
          state_nxt = BURST;
        end
      end
      BURST: begin
        data_nxt = rf_rdata;
        vld_nxt  = onehot(win);
        addr_nxt = cur_addr + 1'b1;
        if (cnt == 2'd0) begin
          last_nxt  = 1'b1;
          state_nxt = IDLE;
          rr_nxt    = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      cur_addr <= '0;
      cnt      <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      win      <= win_nxt;
      cur_addr <= addr_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      rd_valid <= vld_nxt;
      rd_last  <= last_nxt;
      rd_data  <= data_nxt;
    end
  end

  // Select comes straight from a register so the mux input is steady all cycle.
  assign rf_sel = cur_addr;
  assign busy   = (state == BURST);

endmodule
